// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default sizes and index/data types for the multiported register file
package regfile_pkg;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_DATA_WIDTH = 32;
   localparam int REG_DEPTH      = 2**REG_ADDR_WIDTH;
   localparam int REG_NUM_READ   = 4;
   localparam int REG_NUM_WRITE  = 2;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
   typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: picks one winning write port per target index and flags collisions
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int NUM_WRITE  = REG_NUM_WRITE
)(
   input  logic [NUM_WRITE-1:0]                 i_we,
   input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] i_waddr,
   output logic [NUM_WRITE-1:0]                 o_win,
   output logic                                 o_conflict
);
   // a port wins unless a lower-numbered enabled port targets the same non-zero index
   always_comb begin
      o_win      = '0;
      o_conflict = 1'b0;
      for (int p = 0; p < NUM_WRITE; p++) begin
         o_win[p] = i_we[p] && (i_waddr[p] != '0);
         for (int q = 0; q < p; q++) begin
            if (o_win[p] && i_we[q] && (i_waddr[q] == i_waddr[p])) begin
               o_win[p]   = 1'b0;
               o_conflict = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: multiported register file with arbitrated writes, forwarding and busy scoreboard
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int NUM_READ   = REG_NUM_READ,
   parameter int NUM_WRITE  = REG_NUM_WRITE,
   parameter int BYPASS     = 1
)(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  RADDR,
   output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  RD,
   output logic [NUM_READ-1:0]                  BUSY,
   input  logic [NUM_WRITE-1:0]                 WE,
   input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] WADDR,
   input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] WD,
   input  logic                                 RSV_EN,
   input  logic [ADDR_WIDTH-1:0]                RSV_ADDR,
   output logic                                 CONFLICT
);
   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]               r_mem [DEPTH];
   logic [DATA_WIDTH-1:0]               w_mem_nxt [DEPTH];
   logic [DEPTH-1:0]                    r_busy;
   logic [DEPTH-1:0]                    w_busy_nxt;
   logic [NUM_WRITE-1:0]                w_win;
   logic                                w_conflict;
   logic [NUM_READ-1:0][DATA_WIDTH-1:0] w_rd_nxt;
   logic [NUM_READ-1:0]                 w_busy_rd;

   regfile_wr_arbiter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WRITE  (NUM_WRITE)
   ) u_arb (
      .i_we       (WE),
      .i_waddr    (WADDR),
      .o_win      (w_win),
      .o_conflict (w_conflict)
   );

   // post-edge storage image: winners have distinct indices, so port order does not matter
   always_comb begin
      w_mem_nxt = r_mem;
      for (int p = 0; p < NUM_WRITE; p++)
         if (w_win[p]) w_mem_nxt[WADDR[p]] = WD[p];
      w_mem_nxt[0] = '0;
   end

   // scoreboard: any enabled write clears, a reserve sets afterwards so it wins the tie
   always_comb begin
      w_busy_nxt = r_busy;
      for (int p = 0; p < NUM_WRITE; p++)
         if (WE[p]) w_busy_nxt[WADDR[p]] = 1'b0;
      if (RSV_EN) w_busy_nxt[RSV_ADDR] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // read muxes: forwarded (post-write) or pre-write contents, and the post-edge busy bit
   always_comb begin
      w_rd_nxt  = '0;
      w_busy_rd = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         w_rd_nxt[i]  = (BYPASS != 0) ? w_mem_nxt[RADDR[i]] : r_mem[RADDR[i]];
         w_busy_rd[i] = w_busy_nxt[RADDR[i]];
      end
   end

   // storage and scoreboard state; reset wipes everything so nothing partial survives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
         r_busy <= '0;
      end else begin
         r_mem  <= w_mem_nxt;
         r_busy <= w_busy_nxt;
      end
   end

   // registered read data, busy flags and one-cycle collision pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RD       <= '0;
         BUSY     <= '0;
         CONFLICT <= 1'b0;
      end else begin
         RD       <= w_rd_nxt;
         BUSY     <= w_busy_rd;
         CONFLICT <= w_conflict;
      end
   end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter ADDR_WIDTH SHALL default to 5 and sets the register index width; depth is 2**ADDR_WIDTH.
REQ-003 Parameter DATA_WIDTH SHALL default to 32 and sets the register width.
REQ-004 Parameter NUM_READ SHALL default to 4 and sets the number of read ports (range 1..8).
REQ-005 Parameter NUM_WRITE SHALL default to 2 and sets the number of write ports (range 1..4).
REQ-006 Parameter BYPASS SHALL default to 1; value 1 enables write-to-read forwarding and value 0 disables it.
REQ-007 The ports SHALL be as follows:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- RADDR, input, NUM_READ x ADDR_WIDTH: read indices.
- RD, output, NUM_READ x DATA_WIDTH: registered read data.
- BUSY, output, NUM_READ: registered pending-write flag for each read index.
- WE, input, NUM_WRITE: write enables.
- WADDR, input, NUM_WRITE x ADDR_WIDTH: write indices.
- WD, input, NUM_WRITE x DATA_WIDTH: write data.
- RSV_EN, input, 1: reserve request for the scoreboard.
- RSV_ADDR, input, ADDR_WIDTH: index to reserve.
- CONFLICT, output, 1: registered pulse indicating a write collision.

Function
REQ-008 Register 0 SHALL always read as zero; writes to it SHALL be ignored, and it SHALL never be marked busy.
REQ-009 Writes SHALL commit on the rising edge of clk.
REQ-010 When two or more enabled write ports target the same non-zero index in one cycle, the lowest-numbered port SHALL win, and CONFLICT SHALL be asserted for exactly the following cycle.
REQ-011 Reads SHALL be synchronous with 1-cycle latency: RD[i] SHALL equal the contents of RADDR[i] sampled at the edge.
REQ-012 With BYPASS=1, if a winning write targets RADDR[i] in the same cycle, RD[i] SHALL take that write's data.
REQ-013 With BYPASS=0, in the same case RD[i] SHALL take the pre-write contents.
REQ-014 Scoreboard behaviour:
- Each non-zero register SHALL have one busy bit.
- RSV_EN SHALL set the busy bit of RSV_ADDR at the edge.
- Any enabled write to an index SHALL clear that index's busy bit at the edge.
REQ-015 When a reserve and a write hit the same index in one cycle, the reserve SHALL win and the bit SHALL stay set.
REQ-016 BUSY[i] SHALL present the post-edge busy state of RADDR[i], and SHALL be consistent with RD[i] under BYPASS.
REQ-017 Reserving an already-busy index SHALL leave it busy, and no error SHALL be flagged.
REQ-018 Read ports SHALL be fully independent; any number of ports MAY read the same index in the same cycle.

Reset
REQ-019 While rst_n is low, all registers SHALL be zero, all busy bits SHALL be clear, and RD, BUSY and CONFLICT SHALL be zero, independent of clk.
REQ-020 Writes and reserves presented while in reset SHALL be discarded.
REQ-021 The first edge after rst_n deasserts SHALL operate normally.
REQ-022 An assertion of rst_n in mid-operation SHALL abort pending commits and SHALL NOT retain partial state.

Structure
REQ-023 A shared package regfile_pkg SHALL hold the default width and depth constants and the typedefs reg_idx_t and reg_data_t.
REQ-024 Write-port arbitration (winner selection and conflict detection) SHALL be a sub-module named regfile_wr_arbiter.
REQ-025 Storage, bypass and scoreboard SHALL reside in multiport_regfile.

Verification
REQ-026 Reset check -> after reset release, reading indices 0..31 on all ports SHALL return RD=0, BUSY=0 and CONFLICT=0.
REQ-027 Basic write/read -> WE[0]=1, WADDR[0]=5, WD[0]=0xDEADBEEF; the next cycle with RADDR[2]=5 SHALL give RD[2]=0xDEADBEEF one cycle later.
REQ-028 Register-0 write and bypass -> a write of 0x1234 to index 0 SHALL read back RD=0.
REQ-029 Same-cycle forwarding -> a write of 0xA5A5A5A5 to index 7 with RADDR[0]=7 in the same cycle SHALL give RD[0]=0xA5A5A5A5 when BYPASS=1, and the old value 0 when BYPASS=0.
REQ-030 Write collision -> WE=2'b11, both WADDR=9, WD[0]=0x11, WD[1]=0x22 SHALL store 0x11, pulse CONFLICT for one cycle, and no collision SHALL be reported for targets at index 0.
REQ-031 Scoreboard -> reserving index 3 SHALL give BUSY=1 when reading 3; a write to 3 with a simultaneous reserve of 3 SHALL keep BUSY=1; a write to 3 alone SHALL clear it to BUSY=0; asserting rst_n low while busy SHALL clear it immediately.
